dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words stored; SHALL be a power of two.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted between request acceptance and response; legal range 0..15.
REQ-003 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  CPU MEM stage presents a load or store.
REQ-006 req_write  in  1  1 = store, 0 = load; sampled only with req_valid.
REQ-007 req_addr  in  32  byte address.
REQ-008 req_wdata  in  32  store data.
REQ-009 req_ready  out  1  request accepted this cycle when req_valid & req_ready.
REQ-010 resp_valid  out  1  one-cycle response strobe.
REQ-011 resp_rdata  out  32  load data; 0 for stores.
REQ-012 resp_err  out  1  alignment error flag, valid with resp_valid.
REQ-013 stall  out  1  freeze request to the CPU pipeline (PCWrite/IFIDWrite hold).

Function
REQ-014 FSM states SHALL be IDLE, BUSY and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE & req_valid: capture write, addr and wdata, and load wait counter = WAIT_CYCLES; go BUSY if WAIT_CYCLES>0, else RESP.
REQ-017 BUSY: decrement counter each cycle; move to RESP on the edge where counter == 1.
REQ-018 resp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accepting edge and last one cycle; RESP → IDLE unconditionally.
REQ-019 Word index = addr[2 +: log2(DEPTH)]; upper address bits ignored, so addresses wrap modulo DEPTH*4.
REQ-020 Store SHALL commit to the array on the edge entering RESP; resp_rdata = 0.
REQ-021 Load resp_rdata SHALL reflect array contents at the edge entering RESP, including a store committed in the immediately preceding transaction.
REQ-022 stall = req_valid & ~resp_valid (combinational); stall = 0 in IDLE with req_valid low.
REQ-023 A request raised during RESP SHALL wait, unacknowledged, until IDLE the following cycle; back-to-back throughput = one access per WAIT_CYCLES+2 cycles.
REQ-024 resp_rdata and resp_err SHALL hold their values when resp_valid = 0.

Reset
REQ-025 Reset SHALL force: state IDLE, counter 0, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, stall per REQ-022.
REQ-026 Reset during BUSY SHALL discard the pending access; an uncommitted store SHALL NOT reach the array.
REQ-027 Array contents SHALL NOT be cleared by reset and SHALL remain loadable hierarchically by benches.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN defined: addr[1:0] != 0 → no array access, response timing unchanged, resp_err = 1, resp_rdata = 0.
REQ-029 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] ignored, resp_err tied to 0.

Structure
REQ-030 Shared package dmem_pkg SHALL hold the state enum, the WAIT_CYCLES/DEPTH defaults and the counter width constant (4).
REQ-031 Storage SHALL be a sub-module dmem_array (single port, synchronous write, exposed datamem[] array); FSM and counter stay in dmem_responder.

Verification
REQ-032 WAIT_CYCLES=2: store 0x12345678 to 0x00002000, then load 0x00002000 → resp_valid 3 cycles after each accept, load returns 0x12345678.
REQ-033 DEPTH=256: store 0xCAFEF00D to 0x00000400, load 0x00000000 → 0xCAFEF00D (wrap).
REQ-034 WAIT_CYCLES=0: load of preloaded datamem[1]=0x55 at 0x4 → resp_valid on the cycle after accept, stall high exactly 1 cycle.
REQ-035 Reset asserted mid-BUSY of a store of 0xFFFFFFFF to 0x8 → next load of 0x8 returns prior value 0; req_ready = 1 immediately.
REQ-036 DMEM_ALIGN_CHECK_EN: store 0xAA to 0x6 → resp_err = 1, a subsequent load of 0x4 returns the unchanged value; without the macro the same store writes word 1.
REQ-037 req_valid held high across RESP → second accept exactly one cycle after the first resp_valid.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH_DEF = 256;
    localparam int unsigned DMEM_WAIT_DEF  = 2;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH_DEF,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] datamem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            datamem[idx] <= wdata;
        end
    end

    assign rdata = datamem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for the CPU MEM stage.
// Optional alignment checking is enabled with DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = DMEM_DEPTH_DEF,
    parameter int unsigned WAIT_CYCLES = DMEM_WAIT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t         state;
    logic [CNT_W-1:0] cnt;
    logic           cap_write;
    logic [AW-1:0]  cap_idx;
    logic [31:0]    cap_wdata;
    logic           cap_misalign;

    logic           accept_c;
    logic           enter_resp_c;
    logic           req_misalign_c;
    logic           op_write_c;
    logic [AW-1:0]  op_idx_c;
    logic [31:0]    op_wdata_c;
    logic           op_misalign_c;
    logic           we_c;
    logic [31:0]    arr_rdata;
    logic           unused_addr_bits;

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_misalign_c = (req_addr[1:0] != 2'b00);
`else
    assign req_misalign_c = 1'b0;
`endif

    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

    assign accept_c     = (state == IDLE) && req_valid;
    assign enter_resp_c = (accept_c && (WAIT_CYCLES == 0))
                       || ((state == BUSY) && (cnt == CNT_W'(1)));

    // With no wait states the access happens on the accepting edge itself
    assign op_write_c    = accept_c ? req_write      : cap_write;
    assign op_idx_c      = accept_c ? req_addr[2 +: AW] : cap_idx;
    assign op_wdata_c    = accept_c ? req_wdata      : cap_wdata;
    assign op_misalign_c = accept_c ? req_misalign_c : cap_misalign;
    assign we_c          = enter_resp_c && op_write_c && !op_misalign_c;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clock (clock),
        .we    (we_c),
        .idx   (op_idx_c),
        .wdata (op_wdata_c),
        .rdata (arr_rdata)
    );

    assign stall = req_valid && !resp_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
            cap_write    <= 1'b0;
            cap_idx      <= '0;
            cap_wdata    <= '0;
            cap_misalign <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_write    <= req_write;
                        cap_idx      <= req_addr[2 +: AW];
                        cap_wdata    <= req_wdata;
                        cap_misalign <= req_misalign_c;
                        cnt          <= CNT_W'(WAIT_CYCLES);
                        req_ready    <= 1'b0;
                        state        <= (WAIT_CYCLES == 0) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
            // Response data is sampled on the same edge that commits a store
            if (enter_resp_c) begin
                resp_valid <= 1'b1;
                resp_err   <= op_misalign_c;
                resp_rdata <= (op_write_c || op_misalign_c) ? 32'h0 : arr_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: dut_a runs with two wait states, dut_b with none.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst_a, rst_b;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    bit          sel;

    logic        rv_a, rv_b;
    logic        ready_a, ready_b, rvalid_a, rvalid_b, err_a, err_b, stall_a, stall_b;
    logic [31:0] rdata_a, rdata_b;
    logic        m_ready, m_rvalid, m_err, m_stall;
    logic [31:0] m_rdata;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] mem [2][256];

    typedef struct {
        bit          s;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [12];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    assign rv_a     = req_valid & ~sel;
    assign rv_b     = req_valid & sel;
    assign m_ready  = sel ? ready_b  : ready_a;
    assign m_rvalid = sel ? rvalid_b : rvalid_a;
    assign m_rdata  = sel ? rdata_b  : rdata_a;
    assign m_err    = sel ? err_b    : err_a;
    assign m_stall  = sel ? stall_b  : stall_a;

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
        .clock(clock), .reset(rst_a), .req_valid(rv_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_a),
        .resp_valid(rvalid_a), .resp_rdata(rdata_a), .resp_err(err_a), .stall(stall_a)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clock(clock), .reset(rst_b), .req_valid(rv_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_b),
        .resp_valid(rvalid_b), .resp_rdata(rdata_b), .resp_err(err_b), .stall(stall_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: word-addressed memory modulo 256 words, misaligned access rejected when enabled
    task automatic model(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output bit e);
        int idx;
        idx = int'((a / 4) % 256);
        if (ALIGN && (a % 4 != 0)) begin
            rd = 32'h0;
            e  = 1'b1;
        end else begin
            e = 1'b0;
            if (w) begin
                mem[s][idx] = d;
                rd = 32'h0;
            end else begin
                rd = mem[s][idx];
            end
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!m_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!m_ready) chk({nm, " ready timeout"}, 32'(m_ready), 32'h1);
    endtask

    task automatic access(input bit s, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input bit exp_err, input string nm);
        int lat;
        @(negedge clock);
        sel = s; req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        #1;
        wait_ready(nm);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (!m_rvalid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), s ? 32'd1 : 32'd3);
        chk({nm, " rdata"}, m_rdata, exp_rd);
        chk({nm, " err"}, 32'(m_err), 32'(exp_err));
        @(negedge clock);
        chk({nm, " rvalid pulse"}, 32'(m_rvalid), 32'h0);
        chk({nm, " rdata hold"}, m_rdata, exp_rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] erd;
        bit          eerr;
        int          n, sc, a1, a2, pr;

        tbl[0]  = '{1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0000_2000, 32'h0, 32'h1234_5678, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0006, 32'h0000_00AA, 32'h0, ALIGN};
        tbl[5]  = '{1'b0, 1'b0, 32'h0000_0004, 32'h0, ALIGN ? 32'h0 : 32'hAA, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 32'h0000_0007, 32'h0, ALIGN ? 32'h0 : 32'hAA, ALIGN};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0, 32'h0000_0055, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0410, 32'h0, 32'hDEAD_BEEF, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 32'h0000_0004, 32'h0000_0001, 32'h0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 32'hFFFF_FC04, 32'h0, 32'h0000_0001, 1'b0};

        sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dut_a.u_array.datamem[i] = 32'h0;
            dut_b.u_array.datamem[i] = 32'h0;
            mem[0][i] = 32'h0;
            mem[1][i] = 32'h0;
        end
        dut_b.u_array.datamem[1] = 32'h55;
        mem[1][1] = 32'h55;

        // Reset values on both instances
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            chk("reset ready", 32'(m_ready), 32'h1);
            chk("reset rvalid", 32'(m_rvalid), 32'h0);
            chk("reset rdata", m_rdata, 32'h0);
            chk("reset err", 32'(m_err), 32'h0);
            chk("reset stall idle", 32'(m_stall), 32'h0);
            req_valid = 1'b1;
            #1;
            chk("reset stall req", 32'(m_stall), 32'h1);
            req_valid = 1'b0;
        end
        @(negedge clock);
        rst_a = 1'b0; rst_b = 1'b0;

        // Zero wait states: preloaded word, single stall cycle
        @(negedge clock);
        sel = 1'b1; req_write = 1'b0; req_addr = 32'h4; req_valid = 1'b1;
        #1;
        n = 0; sc = 0;
        while (!m_rvalid && n < 10) begin
            if (m_stall) sc++;
            @(negedge clock);
            n++;
        end
        chk("w0 latency", 32'(n), 32'd1);
        chk("w0 stall cycles", 32'(sc), 32'd1);
        chk("w0 rdata", m_rdata, 32'h55);
        chk("w0 stall at resp", 32'(m_stall), 32'h0);
        req_valid = 1'b0;

        for (int i = 0; i < 12; i++) begin
            model(int'(tbl[i].s), tbl[i].w, tbl[i].a, tbl[i].d, erd, eerr);
            access(tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd, tbl[i].exp_err,
                   $sformatf("vec%0d", i));
        end

        // Reset while a store is waiting: store must be discarded
        @(negedge clock);
        sel = 1'b0; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
        #1;
        wait_ready("rstbusy");
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        rst_a = 1'b1;
        #1;
        chk("rstbusy ready", 32'(m_ready), 32'h1);
        chk("rstbusy rvalid", 32'(m_rvalid), 32'h0);
        @(negedge clock);
        rst_a = 1'b0;
        access(1'b0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, "rstbusy load");

        // Request held high across the response: back-to-back spacing
        @(negedge clock);
        sel = 1'b0; req_write = 1'b0; req_addr = 32'h2000; req_valid = 1'b1;
        #1;
        wait_ready("b2b");
        a1 = cyc + 1;
        @(posedge clock);
        @(negedge clock);
        n = 0;
        while (!m_rvalid && n < 20) begin
            @(negedge clock);
            n++;
        end
        pr = cyc;
        chk("b2b resp offset", 32'(pr - a1), 32'd2);
        chk("b2b rdata1", m_rdata, mem[0][0]);
        chk("b2b stall at resp", 32'(m_stall), 32'h0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!m_ready && n < 20);
        a2 = cyc + 1;
        chk("b2b accept spacing", 32'(a2 - a1), 32'd4);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        n = 0;
        while (!m_rvalid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("b2b rdata2", m_rdata, mem[0][0]);
        chk("b2b latency2", 32'(n), 32'd2);

        // Randomized accesses against the reference model
        for (int k = 0; k < 60; k++) begin
            bit          s, w;
            logic [31:0] a, d;
            s = bit'($urandom_range(0, 1));
            w = bit'($urandom_range(0, 1));
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            d = $urandom;
            model(int'(s), w, a, d, erd, eerr);
            access(s, w, a, d, erd, eerr, $sformatf("rnd%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
